// File: rtl/id_entry_pkg.sv
// Shared types and character helpers for the id_entry text editor.
package id_entry_pkg;

    localparam int unsigned CHAR_W = 4;
    localparam logic [CHAR_W-1:0] CHAR_BLANK     = 4'hA;
    localparam logic [CHAR_W-1:0] CHAR_MAX_DIGIT = 4'h9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Character cycle 0..9, blank, back to 0; blank and any invalid code go to 0.
    function automatic logic [CHAR_W-1:0] char_step(input logic [CHAR_W-1:0] c);
        if (c < CHAR_MAX_DIGIT) begin
            return c + 4'd1;
        end else if (c == CHAR_MAX_DIGIT) begin
            return CHAR_BLANK;
        end
        return '0;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw button -> 2-flop synchroniser -> tick-sampled debouncer -> one-clk press pulse.
module key_debounce #(
    parameter int unsigned DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEB_SAMPLES + 1);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    // The level flips only on the last of DEB_SAMPLES samples that all differ from it.
    always_comb begin
        accept = tick && (sync_q[1] != stable_q) && (cnt_q == CNT_W'(DEB_SAMPLES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            press  <= 1'b0;
            if (tick) begin
                if (sync_q[1] == stable_q) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    stable_q <= sync_q[1];
                    cnt_q    <= '0;
                    press    <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/id_entry.sv
// Three-button text editor: edits a buffer copy of text and publishes it with a ld pulse.
// Define ID_ENTRY_AUTOCOMMIT_EN to auto-commit after TIMEOUT_TICKS idle ticks in EDIT.
module id_entry
    import id_entry_pkg::*;
#(
    parameter int unsigned           N_DIGITS      = 11,
    parameter logic [4*N_DIGITS-1:0] TEXT_INIT     = 44'haaa32202008,
    parameter int unsigned           DEB_SAMPLES   = 3,
    parameter int unsigned           TIMEOUT_TICKS = 4000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  btn_inc,
    input  logic                  btn_next,
    input  logic                  btn_commit,
    output logic [4*N_DIGITS-1:0] text,
    output logic                  ld,
    output logic                  editing,
    output logic [3:0]            cursor,
    output logic [3:0]            cur_digit
);

    localparam int unsigned TW = CHAR_W * N_DIGITS;

    logic p_inc, p_next, p_commit;
    logic timeout;

    state_t          state_q, state_d;
    logic [TW-1:0]   ebuf_q, ebuf_d;
    logic [TW-1:0]   text_d;
    logic            ld_d;
    logic            editing_d;
    logic [3:0]      cursor_d;
    logic [3:0]      cur_digit_d;

    key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_inc (
        .clk(clk), .reset(reset), .tick(tick), .btn(btn_inc), .press(p_inc)
    );
    key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_next (
        .clk(clk), .reset(reset), .tick(tick), .btn(btn_next), .press(p_next)
    );
    key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_commit (
        .clk(clk), .reset(reset), .tick(tick), .btn(btn_commit), .press(p_commit)
    );

`ifdef ID_ENTRY_AUTOCOMMIT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             any_press;

    always_comb begin
        any_press = p_inc | p_next | p_commit;
        timeout   = (state_q == EDIT) && tick && !any_press
                    && (tmo_q == TMO_W'(TIMEOUT_TICKS - 1));
    end

    // Idle-tick counter, live only in EDIT and restarted by any press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else if ((state_q != EDIT) || any_press) begin
            tmo_q <= '0;
        end else if (tick) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next state; commit outranks next, next outranks inc.
    always_comb begin
        state_d     = state_q;
        ebuf_d      = ebuf_q;
        text_d      = text;
        ld_d        = 1'b0;
        cursor_d    = cursor;
        cur_digit_d = '0;
        case (state_q)
            IDLE: begin
                if (p_next) begin
                    state_d  = EDIT;
                    ebuf_d   = text;
                    cursor_d = '0;
                end
            end
            EDIT: begin
                if (p_commit || timeout) begin
                    state_d = COMMIT;
                    text_d  = ebuf_q;
                    ld_d    = 1'b1;
                end else if (p_next) begin
                    cursor_d = (cursor == 4'(N_DIGITS - 1)) ? 4'd0 : cursor + 4'd1;
                end else if (p_inc) begin
                    for (int unsigned i = 0; i < N_DIGITS; i++) begin
                        if (cursor == 4'(i)) begin
                            ebuf_d[(N_DIGITS-1-i)*CHAR_W +: CHAR_W] =
                                char_step(ebuf_q[(N_DIGITS-1-i)*CHAR_W +: CHAR_W]);
                        end
                    end
                end
            end
            COMMIT: begin
                state_d  = IDLE;
                cursor_d = '0;
            end
            default: begin
                state_d  = IDLE;
                cursor_d = '0;
            end
        endcase
        editing_d = (state_d == EDIT);
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (cursor_d == 4'(i)) begin
                cur_digit_d = ebuf_d[(N_DIGITS-1-i)*CHAR_W +: CHAR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ebuf_q    <= TEXT_INIT;
            text      <= TEXT_INIT;
            ld        <= 1'b0;
            editing   <= 1'b0;
            cursor    <= '0;
            cur_digit <= TEXT_INIT[TW-1 -: CHAR_W];
        end else begin
            state_q   <= state_d;
            ebuf_q    <= ebuf_d;
            text      <= text_d;
            ld        <= ld_d;
            editing   <= editing_d;
            cursor    <= cursor_d;
            cur_digit <= cur_digit_d;
        end
    end

endmodule

// File: tb/tb_id_entry.sv
// Directed bench for id_entry: commit scoreboard plus immediate-assertion checks.
module tb_id_entry;

    localparam logic [43:0] INIT = 44'haaa32202008;
    localparam logic [2:0]  B_INC = 3'b001;
    localparam logic [2:0]  B_NXT = 3'b010;
    localparam logic [2:0]  B_CMT = 3'b100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_commit = 1'b0;
    logic [43:0] text;
    logic        ld;
    logic        editing;
    logic [3:0]  cursor;
    logic [3:0]  cur_digit;

    int          tests = 0;
    int          fails = 0;
    int          ld_cnt = 0;
    logic        ld_prev = 1'b0;
    logic [43:0] sb[$];
    logic [43:0] exp_text;
    logic [3:0]  exp_digit;

    always #5 clk = ~clk;

    id_entry #(
        .N_DIGITS(11),
        .TEXT_INIT(44'haaa32202008),
        .DEB_SAMPLES(3),
        .TIMEOUT_TICKS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .btn_inc(btn_inc),
        .btn_next(btn_next),
        .btn_commit(btn_commit),
        .text(text),
        .ld(ld),
        .editing(editing),
        .cursor(cursor),
        .cur_digit(cur_digit)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every ld pulse pops the next expected commit value and must last one clk.
    always @(negedge clk) begin
        if (ld === 1'b1) begin
            ld_cnt++;
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL ld_unexpected: observed ld=1 expected no pulse");
            end
            if (sb.size() > 0) begin
                exp_text = sb.pop_front();
                tests++;
                assert (text === exp_text) else begin
                    fails++;
                    $error("FAIL ld_text: observed %0h expected %0h", text, exp_text);
                end
            end
            tests++;
            assert (ld_prev === 1'b0) else begin
                fails++;
                $error("FAIL ld_width: observed ld high 2 clks expected 1");
            end
        end
        ld_prev = ld;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic set_btns(input logic [2:0] v);
        {btn_commit, btn_next, btn_inc} = v;
    endtask

    // Clean press: settle, 3 held ticks, then release with 3 ticks.
    task automatic press(input logic [2:0] v);
        set_btns(v);
        wait_clk(3);
        repeat (3) do_tick();
        wait_clk(2);
        set_btns(3'b000);
        wait_clk(3);
        repeat (3) do_tick();
        wait_clk(2);
    endtask

    initial begin
        wait_clk(2);
        check("rst_text", text, INIT);
        check("rst_ld", ld, 1'b0);
        check("rst_editing", editing, 1'b0);
        check("rst_cursor", cursor, 4'd0);
        check("rst_cur_digit", cur_digit, 4'hA);
        reset = 1'b0;
        wait_clk(2);

        // inc and commit are ignored in IDLE
        press(B_INC);
        press(B_CMT);
        check("idle_ignore_editing", editing, 1'b0);
        check("idle_ignore_text", text, INIT);
        check("idle_ignore_ld", 64'(ld_cnt), 64'd0);

        // bounce 1-0-1 then held: single press only after third stable sample
        btn_next = 1'b1; wait_clk(3); do_tick();
        btn_next = 1'b0; wait_clk(3); do_tick();
        btn_next = 1'b1; wait_clk(3); do_tick(); do_tick();
        wait_clk(2);
        check("bounce_no_press", editing, 1'b0);
        do_tick();
        wait_clk(2);
        check("bounce_press", editing, 1'b1);
        check("bounce_cursor", cursor, 4'd0);
        check("bounce_digit", cur_digit, 4'hA);
        btn_next = 1'b0; wait_clk(3);
        repeat (3) do_tick();
        wait_clk(2);
        check("release_no_press", cursor, 4'd0);

        // inc x3 on cursor 0: A -> 0 -> 1 -> 2, text untouched until commit
        for (int k = 0; k < 3; k++) begin
            press(B_INC);
            check("inc_digit", cur_digit, 4'(k));
            check("inc_text_hidden", text, INIT);
        end
        sb.push_back(44'h2aa32202008);
        press(B_CMT);
        check("commit_editing", editing, 1'b0);
        check("commit_cursor", cursor, 4'd0);
        check("commit_text", text, 44'h2aa32202008);
        check("commit_ld_cnt", 64'(ld_cnt), 64'd1);

        // cursor walk and wrap
        press(B_NXT);
        check("edit2_enter", editing, 1'b1);
        check("edit2_digit0", cur_digit, 4'h2);
        repeat (10) press(B_NXT);
        check("cursor_10", cursor, 4'd10);
        check("cursor_10_digit", cur_digit, 4'h8);
        press(B_NXT);
        check("cursor_wrap", cursor, 4'd0);
        repeat (10) press(B_NXT);

        // inc x11 on digit 8: 9, A, 0, 1, ..., 8
        for (int k = 0; k < 11; k++) begin
            press(B_INC);
            exp_digit = (k == 0) ? 4'h9 : (k == 1) ? 4'hA : 4'(k - 2);
            check("inc_cycle", cur_digit, exp_digit);
        end
        press(B_INC);
        check("inc_to_9", cur_digit, 4'h9);

        // commit, next and inc in the same clk: only commit acts
        sb.push_back(44'h2aa32202009);
        press(B_CMT | B_NXT | B_INC);
        check("prio_editing", editing, 1'b0);
        check("prio_cursor", cursor, 4'd0);
        check("prio_text", text, 44'h2aa32202009);
        check("prio_ld_cnt", 64'(ld_cnt), 64'd2);

        // idle timeout behaviour
        press(B_NXT);
        check("tmo_enter", editing, 1'b1);
`ifdef ID_ENTRY_AUTOCOMMIT_EN
        repeat (4) do_tick();
        wait_clk(2);
        check("tmo_before", editing, 1'b1);
        check("tmo_before_ld", 64'(ld_cnt), 64'd2);
        sb.push_back(44'h2aa32202009);
        do_tick();
        wait_clk(2);
        check("tmo_fired", editing, 1'b0);
        check("tmo_ld_cnt", 64'(ld_cnt), 64'd3);
        check("tmo_cursor", cursor, 4'd0);
`else
        repeat (100) do_tick();
        wait_clk(2);
        check("no_tmo_editing", editing, 1'b1);
        check("no_tmo_ld", 64'(ld_cnt), 64'd2);
        sb.push_back(44'h2aa32202009);
        press(B_CMT);
        check("no_tmo_commit", 64'(ld_cnt), 64'd3);
`endif

        // reset mid-edit discards the buffer silently
        press(B_NXT);
        press(B_INC);
        check("pre_rst_digit", cur_digit, 4'h3);
        @(negedge clk) reset = 1'b1;
        #1;
        check("async_rst_editing", editing, 1'b0);
        check("async_rst_text", text, INIT);
        check("async_rst_cursor", cursor, 4'd0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(2);
        check("rst_edit_ld_cnt", 64'(ld_cnt), 64'd3);
        check("rst_edit_digit", cur_digit, 4'hA);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
